// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: in-order writeback vs. buffered long-latency results.
// Optional destination scoreboard enabled by defining WBARB_SCOREBOARD_EN.
module wb_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       CLK_WBArb,
  input  logic                       RST_WBArb,
  input  logic                       P_WE,
  input  logic [4:0]                 P_A3,
  input  logic [31:0]                P_WD,
  output logic                       P_Stall,
  input  logic                       L_Valid,
  output logic                       L_Ready,
  input  logic [4:0]                 L_A3,
  input  logic [31:0]                L_WD,
  input  logic                       Issue_Valid,
  input  logic [4:0]                 Issue_A3,
  output logic                       WE3,
  output logic [4:0]                 A3,
  output logic [31:0]                WD3,
  output logic [31:0]                Busy,
  output logic [$clog2(DEPTH+1)-1:0] Pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  logic [4:0]    r_mem_a3 [DEPTH];
  logic [31:0]   r_mem_wd [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_we3;
  logic [4:0]    r_a3;
  logic [31:0]   r_wd3;

  logic          w_empty;
  logic          w_full;
  logic          w_forced;
  logic          w_push;
  logic          w_pop;
  logic          w_we_nxt;
  logic [4:0]    w_a3_nxt;
  logic [31:0]   w_wd_nxt;
  logic [4:0]    w_head_a3;
  logic [31:0]   w_head_wd;

  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_full    = (r_count == FULL_C);
  assign w_forced  = !w_empty && (r_starve == STARVE_C);
  assign w_head_a3 = r_mem_a3[r_rptr];
  assign w_head_wd = r_mem_wd[r_rptr];

  // Ready depends on occupancy only, so a full FIFO refuses even while popping.
  assign L_Ready = !RST_WBArb && !w_full;
  assign w_push  = L_Valid && L_Ready;
  assign w_pop   = !w_empty && (w_forced || !P_WE);
  assign P_Stall = w_forced;

  always_comb begin
    w_we_nxt = 1'b0;
    w_a3_nxt = r_a3;
    w_wd_nxt = r_wd3;
    if (w_pop) begin
      w_we_nxt = (w_head_a3 != 5'd0);
      w_a3_nxt = w_head_a3;
      w_wd_nxt = w_head_wd;
    end else if (P_WE) begin
      w_we_nxt = (P_A3 != 5'd0);
      w_a3_nxt = P_A3;
      w_wd_nxt = P_WD;
    end else begin
      w_we_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK_WBArb) begin
    if (w_push) begin
      r_mem_a3[r_wptr] <= L_A3;
      r_mem_wd[r_wptr] <= L_WD;
    end
  end

  always_ff @(posedge CLK_WBArb or posedge RST_WBArb) begin
    if (RST_WBArb) begin
      r_wptr   <= {AW{1'b0}};
      r_rptr   <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_starve <= {SW{1'b0}};
      r_we3    <= 1'b0;
      r_a3     <= 5'd0;
      r_wd3    <= 32'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A non-empty FIFO that is not popped has necessarily lost to the pipeline.
      if (w_empty || w_pop)
        r_starve <= {SW{1'b0}};
      else if (r_starve != STARVE_C)
        r_starve <= r_starve + SW'(1);
      else
        r_starve <= r_starve;
      r_we3 <= w_we_nxt;
      r_a3  <= w_a3_nxt;
      r_wd3 <= w_wd_nxt;
    end
  end

`ifdef WBARB_SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  assign w_set_mask = (Issue_Valid && (Issue_A3 != 5'd0)) ? (32'h1 << Issue_A3) : 32'h0;
  assign w_clr_mask = w_pop ? (32'h1 << w_head_a3) : 32'h0;

  // Set is applied after clear so a same-cycle issue to the drained register wins.
  always_ff @(posedge CLK_WBArb or posedge RST_WBArb) begin
    if (RST_WBArb) r_busy <= 32'h0;
    else           r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
  end

  assign Busy = r_busy;
`else
  logic w_unused_issue;
  assign w_unused_issue = Issue_Valid ^ (^Issue_A3);
  assign Busy = 32'h0;
`endif

  assign WE3     = r_we3;
  assign A3      = r_a3;
  assign WD3     = r_wd3;
  assign Pending = r_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized + directed bench for wb_write_arbiter against a queue-based reference model.
module tb_wb_write_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_we;
  logic [4:0]  p_a3;
  logic [31:0] p_wd;
  logic        p_stall;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_a3;
  logic [31:0] l_wd;
  logic        issue_valid;
  logic [4:0]  issue_a3;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] busy;
  logic [2:0]  pending;

  ent_t        fq[$];
  int          m_starve;
  logic        m_we3;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  logic [31:0] m_busy;
  int          n_cmp = 0;
  int          n_bad = 0;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK_WBArb  (clk),
    .RST_WBArb  (rst),
    .P_WE       (p_we),
    .P_A3       (p_a3),
    .P_WD       (p_wd),
    .P_Stall    (p_stall),
    .L_Valid    (l_valid),
    .L_Ready    (l_ready),
    .L_A3       (l_a3),
    .L_WD       (l_wd),
    .Issue_Valid(issue_valid),
    .Issue_A3   (issue_a3),
    .WE3        (we3),
    .A3         (a3),
    .WD3        (wd3),
    .Busy       (busy),
    .Pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    p_we = 1'b0; p_a3 = 5'd0; p_wd = 32'd0;
    l_valid = 1'b0; l_a3 = 5'd0; l_wd = 32'd0;
    issue_valid = 1'b0; issue_a3 = 5'd0;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    fq.delete();
    m_starve = 0; m_we3 = 1'b0; m_a3 = 5'd0; m_wd3 = 32'd0; m_busy = 32'd0;
    check_eq("rst_we3", we3, 1'b0);
    check_eq("rst_pending", pending, 3'd0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_l_ready", l_ready, 1'b0);
    check_eq("rst_p_stall", p_stall, 1'b0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_l_ready", l_ready, 1'b0);
    check_eq("rst_hold_we3", we3, 1'b0);
    rst = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    bit   empty, forced, ready;
    ent_t h;
    #4;
    empty  = (fq.size() == 0);
    forced = !empty && (m_starve == STARVE_MAX);
    ready  = (fq.size() < DEPTH);
    check_eq("p_stall", p_stall, forced);
    check_eq("l_ready", l_ready, ready);
    if (!empty && (forced || !p_we)) begin
      h = fq.pop_front();
      m_we3 = (h.a3 != 5'd0); m_a3 = h.a3; m_wd3 = h.wd;
      m_busy[h.a3] = 1'b0;
      m_starve = 0;
    end else if (p_we) begin
      m_we3 = (p_a3 != 5'd0); m_a3 = p_a3; m_wd3 = p_wd;
      if (empty) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
    end else begin
      m_we3 = 1'b0;
      m_starve = 0;
    end
    if (l_valid && ready) fq.push_back('{a3: l_a3, wd: l_wd});
`ifdef WBARB_SCOREBOARD_EN
    if (issue_valid && issue_a3 != 5'd0) m_busy[issue_a3] = 1'b1;
`endif
    @(posedge clk);
    #1;
    check_eq("we3", we3, m_we3);
    check_eq("a3", a3, m_a3);
    check_eq("wd3", wd3, m_wd3);
    check_eq("pending", pending, fq.size());
    check_eq("busy", busy, m_busy);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    do_reset();

    // Pipeline beats a waiting FIFO entry, which drains the following cycle.
    l_valid = 1'b1; l_a3 = 5'd7; l_wd = 32'h22;
    tick();
    l_valid = 1'b0; p_we = 1'b1; p_a3 = 5'd5; p_wd = 32'h11;
    tick();
    check_eq("prio_first_a3", a3, 5'd5);
    check_eq("prio_first_wd", wd3, 32'h11);
    p_we = 1'b0;
    tick();
    check_eq("prio_second_we", we3, 1'b1);
    check_eq("prio_second_a3", a3, 5'd7);
    check_eq("prio_second_wd", wd3, 32'h22);

    // Writes to $0 never assert WE3 but are consumed.
    p_we = 1'b1; p_a3 = 5'd0; p_wd = 32'hDEAD;
    tick();
    check_eq("r0_we3", we3, 1'b0);
    check_eq("r0_wd3", wd3, 32'hDEAD);
    p_we = 1'b0;
    tick();
    check_eq("r0_consumed", we3, 1'b0);

    // Fill the FIFO under pipeline pressure; a fifth result waits for a pop.
    do_reset();
    p_we = 1'b1; p_a3 = 5'd3; p_wd = 32'h33;
    for (int i = 0; i < DEPTH; i++) begin
      l_valid = 1'b1; l_a3 = 5'(i + 1); l_wd = 32'h100 + 32'(i);
      tick();
    end
    check_eq("full_l_ready", l_ready, 1'b0);
    check_eq("full_pending", pending, 3'd4);
    l_a3 = 5'd5; l_wd = 32'h105;
    for (int i = 0; i < 8; i++) tick();
    l_valid = 1'b0; p_we = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("full_drained", pending, 3'd0);

    // Starvation: eight lost cycles, then one forced write of the head.
    do_reset();
    p_we = 1'b1; p_a3 = 5'd4; p_wd = 32'h44;
    l_valid = 1'b1; l_a3 = 5'd12; l_wd = 32'hC0FFEE;
    tick();
    l_valid = 1'b0;
    for (int i = 0; i < STARVE_MAX; i++) begin
      check_eq("starve_no_stall", p_stall, 1'b0);
      tick();
    end
    check_eq("starve_stall", p_stall, 1'b1);
    tick();
    check_eq("starve_head_a3", a3, 5'd12);
    check_eq("starve_head_wd", wd3, 32'hC0FFEE);
    check_eq("starve_released", p_stall, 1'b0);
    p_we = 1'b0;

    // Scoreboard: a same-cycle issue to the drained register keeps it busy.
    do_reset();
    issue_valid = 1'b1; issue_a3 = 5'd9;
    tick();
`ifdef WBARB_SCOREBOARD_EN
    check_eq("sb_set", busy[9], 1'b1);
`else
    check_eq("sb_off", busy, 32'h0);
`endif
    issue_valid = 1'b0; p_we = 1'b1; p_a3 = 5'd1;
    l_valid = 1'b1; l_a3 = 5'd9; l_wd = 32'h99;
    tick();
    l_valid = 1'b0; p_we = 1'b0;
    issue_valid = 1'b1; issue_a3 = 5'd9;
    tick();
`ifdef WBARB_SCOREBOARD_EN
    check_eq("sb_set_wins", busy[9], 1'b1);
`else
    check_eq("sb_off_still", busy, 32'h0);
`endif
    check_eq("sb_pop_a3", a3, 5'd9);
    issue_valid = 1'b0;

    // Reset while draining three queued results.
    do_reset();
    p_we = 1'b1; p_a3 = 5'd2; p_wd = 32'h2;
    for (int i = 0; i < 3; i++) begin
      l_valid = 1'b1; l_a3 = 5'(20 + i); l_wd = 32'h200 + 32'(i);
      issue_valid = 1'b1; issue_a3 = 5'(20 + i);
      tick();
    end
    idle_inputs();
    tick();
    check_eq("middrain_we3", we3, 1'b1);
    do_reset();
    tick();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      p_we        = ($urandom_range(0, 99) < 70);
      p_a3        = 5'($urandom_range(0, 31));
      p_wd        = $urandom;
      l_valid     = ($urandom_range(0, 99) < 45);
      l_a3        = 5'($urandom_range(0, 31));
      l_wd        = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_a3    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-side arbiter for the single register-file write port (WE3/A3/WD3) in the pipelined MIPS core. Merges the in-order writeback stage with results from the long-latency unit (multiply/divide). Long-latency results are buffered in a small FIFO and drained into the write port when the pipeline is not writing. An optional destination scoreboard exposes pending-write bits to the hazard unit.

## Interface
Parameters:
- DEPTH, 4: long-latency result FIFO entries (power of two, ≥2)
- STARVE_MAX, 8: consecutive lost-arbitration cycles before the FIFO is forced through

Ports:
- CLK_WBArb  in  1  clock, all state on rising edge
- RST_WBArb  in  1  reset, asynchronous, active-high
- P_WE  in  1  pipeline writeback request
- P_A3  in  5  pipeline destination register
- P_WD  in  32  pipeline write data
- P_Stall  out  1  combinational; pipeline must hold its WB request this cycle
- L_Valid  in  1  long-latency result valid
- L_Ready  out  1  FIFO can accept
- L_A3  in  5  long-latency destination
- L_WD  in  32  long-latency data
- Issue_Valid  in  1  long-latency op issued this cycle
- Issue_A3  in  5  its destination register
- WE3  out  1  register-file write enable (registered)
- A3  out  5  register-file write address (registered)
- WD3  out  32  register-file write data (registered)
- Busy  out  32  per-register pending long-latency write (registered)
- Pending  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Reset: WE3=0, A3=0, WD3=0, Busy=0, Pending=0, P_Stall=0, L_Ready=0 while RST_WBArb is high. FIFO is empty and the starve counter is 0.
- FIFO push: on a rising edge with L_Valid && L_Ready. L_Ready = !RST_WBArb && (Pending != DEPTH).
- There is no pass-through: the ready decision depends only on occupancy, so a full FIFO deasserts L_Ready even when a pop is occurring in the same cycle.
- Arbitration, evaluated each cycle:
  - **Forced:** FIFO non-empty and starve counter == STARVE_MAX. FIFO head wins; P_Stall=1.
  - **Pipeline:** otherwise, if P_WE, the pipeline wins.
  - **FIFO:** otherwise, if the FIFO is non-empty, the head is popped.
  - **Idle:** otherwise, WE3=0 next cycle.
- Starve counter:
  - Increments on each edge where the FIFO is non-empty and the pipeline wins.
  - Clears when the FIFO wins or the FIFO is empty.
  - Saturates at STARVE_MAX.
- Winner is loaded into the WE3/A3/WD3 registers at the edge.
- Register $0: a winning write with address 0 loads WE3=0 (A3/WD3 are still loaded). The source is consumed normally.
- Scoreboard:
  - Issue_Valid with Issue_A3≠0 sets Busy[Issue_A3].
  - A FIFO pop clears Busy[head A3].
  - Same register set and cleared in the same cycle: set wins.
  - Pipeline writes never touch Busy. WAW ordering is the hazard unit's job.
- Pointers wrap modulo DEPTH. Push and pop in the same cycle leaves Pending unchanged.
- Reset asserted mid-operation: FIFO contents are discarded immediately and outputs return to reset values asynchronously.

## Timing
- Pipeline write: P_WE sampled at edge N → WE3/A3/WD3 valid from edge N to edge N+1. The register file commits at edge N+1.
- Long-latency write: pushed at edge N → earliest on WE3 after edge N+1 (FIFO idle, P_WE=0).
- P_Stall is combinational from the starve counter and FIFO-empty state only. It has no path from P_WE, so there is no combinational loop.
- Busy updates one edge after Issue_Valid or pop.
- L_Ready deasserts in the cycle after the push that fills the FIFO.

## Configuration
- WBARB_SCOREBOARD_EN defined: Busy tracking as described.
- Undefined: Busy is tied to 0, and Issue_Valid/Issue_A3 are ignored (ports remain present). Arbitration and FIFO are unchanged.

## Test plan
- Reset mid-drain:
  - Stimulus: 3 entries queued, assert RST_WBArb.
  - Required: WE3=0, Pending=0 and Busy=0 immediately; L_Ready=0 until release, then 1.
- Priority:
  - Stimulus: P_WE=1 (A3=5, WD=0x11) and FIFO holding (A3=7, WD=0x22).
  - Required: WE3 writes 5/0x11 first, then 7/0x22 the next cycle if P_WE=0.
- Full FIFO:
  - Stimulus: push DEPTH=4 entries with P_WE held high.
  - Required: L_Ready=0 after the 4th push. A 5th L_Valid is held unaccepted until a pop.
- Starvation:
  - Stimulus: FIFO non-empty, P_WE high continuously.
  - Required: after exactly 8 lost cycles, P_Stall=1 for one cycle and the FIFO head is written; the counter clears.
- $0 write:
  - Stimulus: P_WE with P_A3=0, WD=0xDEAD.
  - Required: WE3 stays 0; the pipeline request is consumed.
- Scoreboard (with WBARB_SCOREBOARD_EN):
  - Stimulus: Issue_A3=9 → Busy[9]=1 next edge; pop of A3=9 in the same cycle as a new Issue_A3=9.
  - Required: Busy[9] remains 1.
